// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the MC-CPU control path: opcodes, FSM state codes,
// ALU operation codes (also used by the ALU) and PC source selects.
package mc_cpu_pkg;

    localparam int OPCODE_W = 6;
    localparam int STATE_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 6'b010000;
    localparam logic [OPCODE_W-1:0] OP_AND  = 6'b010001;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'b010010;
    localparam logic [OPCODE_W-1:0] OP_SLL  = 6'b011000;
    localparam logic [OPCODE_W-1:0] OP_SLT  = 6'b100110;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'b110000;
    localparam logic [OPCODE_W-1:0] OP_LW   = 6'b110001;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'b111000;
    localparam logic [OPCODE_W-1:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_BR,
        CLS_LS,
        CLS_JMP,
        CLS_HALT
    } instr_class_e;

    typedef struct packed {
        instr_class_e cls;
        logic [2:0]   alu_sel;
        logic         alu_src_a;
        logic         alu_src_b;
        logic         ext_sel;
        logic         wr_reg_dst;
    } decode_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Opcode decoder: instruction class plus the static datapath selects that
// depend only on the opcode.
module mc_ctrl_decode
    import mc_cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] op_i,
    output decode_t             dec_o
);

    always_comb begin
        // NOTE: every field gets a default before the case so that no
        // opcode path leaves a field unassigned and infers a latch.
        dec_o.cls        = CLS_NOP;
        dec_o.alu_sel    = ALU_ADD;
        dec_o.alu_src_a  = 1'b0;
        dec_o.alu_src_b  = 1'b0;
        dec_o.ext_sel    = 1'b0;
        dec_o.wr_reg_dst = 1'b0;
        case (op_i)
            OP_ADD:  begin dec_o.cls = CLS_ALU; dec_o.wr_reg_dst = 1'b1; end
            OP_ADDI: begin
                dec_o.cls       = CLS_ALU;
                dec_o.alu_src_b = 1'b1;
                dec_o.ext_sel   = 1'b1;
            end
            OP_SUB:  begin dec_o.cls = CLS_ALU; dec_o.alu_sel = ALU_SUB; dec_o.wr_reg_dst = 1'b1; end
            OP_ORI:  begin dec_o.cls = CLS_ALU; dec_o.alu_sel = ALU_OR;  dec_o.alu_src_b = 1'b1; end
            OP_AND:  begin dec_o.cls = CLS_ALU; dec_o.alu_sel = ALU_AND; dec_o.wr_reg_dst = 1'b1; end
            OP_OR:   begin dec_o.cls = CLS_ALU; dec_o.alu_sel = ALU_OR;  dec_o.wr_reg_dst = 1'b1; end
            OP_SLL:  begin
                // Shift amount comes from the shamt field on operand A.
                dec_o.cls        = CLS_ALU;
                dec_o.alu_sel    = ALU_SLL;
                dec_o.alu_src_a  = 1'b1;
                dec_o.wr_reg_dst = 1'b1;
            end
            OP_SLT:  begin dec_o.cls = CLS_ALU; dec_o.alu_sel = ALU_SLT; dec_o.wr_reg_dst = 1'b1; end
            OP_SW, OP_LW: dec_o.cls = CLS_LS;
            OP_BEQ:  dec_o.cls = CLS_BR;
            OP_J:    dec_o.cls = CLS_JMP;
            OP_HALT: dec_o.cls = CLS_HALT;
            default: dec_o.cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: sequences one instruction at a time through
// IF/ID/EXE/MEM/WB and drives the datapath selects and write enables.
module mc_control_unit
    import mc_cpu_pkg::*;
#(
    parameter int OP_W = OPCODE_W,
    parameter int ST_W = STATE_W
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            PCWre,
    output logic            IRWre,
    output logic [1:0]      PCSrc,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic            ExtSel,
    output logic [2:0]      ALUSel,
    output logic            WrRegDst,
    output logic            RegWre,
    output logic            DBDataSrc,
    output logic            mRD,
    output logic            mWR,
    output logic [ST_W-1:0] state
);

    state_e          state_q;
    logic [OP_W-1:0] op_q;
    logic            halt_q;
    logic [OP_W-1:0] dec_op;
    decode_t         dec;

    // In ID the opcode is not yet latched, so decode the live IR field there.
    assign dec_op = (state_q == S_ID && !halt_q) ? opcode : op_q;

    mc_ctrl_decode u_decode (
        .op_i  (dec_op),
        .dec_o (dec)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values and the update order inside the block
    // cannot change behaviour.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IF;
            op_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IF:     state_q <= S_ID;
                S_ID: begin
                    if (!halt_q) begin
                        op_q <= opcode;
                        case (dec.cls)
                            CLS_ALU:  state_q <= S_EXE_AL;
                            CLS_BR:   state_q <= S_EXE_BR;
                            CLS_LS:   state_q <= S_EXE_LS;
                            CLS_HALT: halt_q  <= 1'b1;
                            default:  state_q <= S_IF;
                        endcase
                    end
                end
                S_EXE_AL: state_q <= S_WB_AL;
                S_EXE_LS: state_q <= S_MEM;
                S_MEM:    state_q <= (op_q == OP_LW) ? S_WB_LD : S_IF;
                default:  state_q <= S_IF;
            endcase
        end
    end

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        PCSrc     = PC_NEXT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUSel    = ALU_ADD;
        WrRegDst  = 1'b0;
        RegWre    = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        if (!halt_q) begin
            case (state_q)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    if (dec.cls == CLS_JMP) begin
                        PCWre = 1'b1;
                        PCSrc = PC_JUMP;
                    end else if (dec.cls == CLS_NOP) begin
                        PCWre = 1'b1;
                    end
                end
                S_EXE_AL: begin
                    ALUSel  = dec.alu_sel;
                    ALUSrcA = dec.alu_src_a;
                    ALUSrcB = dec.alu_src_b;
                    ExtSel  = dec.ext_sel;
                end
                S_EXE_BR: begin
                    ALUSel = ALU_SUB;
                    PCWre  = 1'b1;
                    PCSrc  = zero ? PC_BRANCH : PC_NEXT;
                end
                S_EXE_LS: begin
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                end
                S_MEM: begin
                    mWR   = (op_q == OP_SW);
                    PCWre = (op_q == OP_SW);
                    mRD   = (op_q == OP_LW);
                end
                S_WB_AL: begin
                    RegWre   = 1'b1;
                    PCWre    = 1'b1;
                    WrRegDst = dec.wr_reg_dst;
                end
                S_WB_LD: begin
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                    PCWre     = 1'b1;
                end
                default: ;
            endcase
        end
        // A reset cycle aborts the instruction with no architectural write.
        if (RST) begin
            PCWre  = 1'b0;
            IRWre  = 1'b0;
            RegWre = 1'b0;
            mRD    = 1'b0;
            mWR    = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: each driven cycle queues its expected
// output vector; a monitor on the falling edge pops and compares.
module tb_mc_control_unit;

    localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EXE_AL = 3'b110,
                           ST_EXE_BR = 3'b101, ST_EXE_LS = 3'b010, ST_MEM = 3'b011,
                           ST_WB_AL = 3'b111, ST_WB_LD = 3'b100;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_IR   = 5'b01000;

    // en = {PCWre, IRWre, RegWre, mRD, mWR}; sel = {ALUSrcA, ALUSrcB, ExtSel, WrRegDst, DBDataSrc}
    typedef struct packed {
        logic [2:0] st;
        logic [4:0] en;
        logic [1:0] pcsrc;
        logic [2:0] alu;
        logic [4:0] sel;
    } exp_t;

    typedef struct {
        string nm;
        exp_t  e;
    } sb_item_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] opcode = 6'b000000;
    logic       zero = 1'b0;
    logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, WrRegDst, RegWre, DBDataSrc, mRD, mWR;
    logic [1:0] PCSrc;
    logic [2:0] ALUSel;
    logic [2:0] state;

    sb_item_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;
    int n_push = 0;
    int n_pop  = 0;

    mc_control_unit #(.OP_W(6), .ST_W(3)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .opcode    (opcode),
        .zero      (zero),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .PCSrc     (PCSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .ALUSel    (ALUSel),
        .WrRegDst  (WrRegDst),
        .RegWre    (RegWre),
        .DBDataSrc (DBDataSrc),
        .mRD       (mRD),
        .mWR       (mWR),
        .state     (state)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t mk(input logic [2:0] st, input logic [4:0] en,
                                input logic [1:0] pcsrc, input logic [2:0] alu,
                                input logic [4:0] sel);
        exp_t e;
        e.st = st; e.en = en; e.pcsrc = pcsrc; e.alu = alu; e.sel = sel;
        return e;
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue what the
    // outputs must look like for the remainder of that cycle.
    task automatic step(input string nm, input logic [5:0] op, input logic z,
                        input logic r, input exp_t e);
        sb_item_t it;
        @(posedge CLK);
        #1;
        RST    = r;
        opcode = op;
        zero   = z;
        it.nm  = nm;
        it.e   = e;
        sb.push_back(it);
        n_push++;
    endtask

    // IF, ID, EXE_AL, WB_AL; the IR field is scrambled after ID and zero is
    // toggled to show both are ignored once the opcode is latched.
    task automatic run_alu(input string nm, input logic [5:0] op, input logic [2:0] alu,
                           input logic [4:0] exe_sel, input logic [4:0] wb_sel);
        step({nm, ".IF"},  op,          1'b0, 1'b0, mk(ST_IF,     EN_IR,    2'b00, 3'b000, 5'b00000));
        step({nm, ".ID"},  op,          1'b0, 1'b0, mk(ST_ID,     EN_NONE,  2'b00, 3'b000, 5'b00000));
        step({nm, ".EXE"}, 6'b111111,   1'b1, 1'b0, mk(ST_EXE_AL, EN_NONE,  2'b00, alu,    exe_sel));
        step({nm, ".WB"},  6'b111000,   1'b1, 1'b0, mk(ST_WB_AL,  5'b10100, 2'b00, 3'b000, wb_sel));
    endtask

    initial begin : monitor
        sb_item_t it;
        exp_t     act;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                n_pop++;
                act = mk(state, {PCWre, IRWre, RegWre, mRD, mWR}, PCSrc, ALUSel,
                         {ALUSrcA, ALUSrcB, ExtSel, WrRegDst, DBDataSrc});
                n_chk++;
                if (act !== it.e) begin
                    n_fail++;
                    $display("FAIL %s: got st=%b en=%b pcsrc=%b alu=%b sel=%b, expected st=%b en=%b pcsrc=%b alu=%b sel=%b",
                             it.nm, act.st, act.en, act.pcsrc, act.alu, act.sel,
                             it.e.st, it.e.en, it.e.pcsrc, it.e.alu, it.e.sel);
                end
            end
        end
    end

    initial begin : stimulus
        // Reset: enables forced low while RST is high.
        step("rst0", 6'b000000, 1'b0, 1'b1, mk(ST_IF, EN_NONE, 2'b00, 3'b000, 5'b00000));

        // ALU ops: name, opcode, ALUSel, EXE selects, WB selects (WrRegDst)
        run_alu("add",  6'b000000, 3'b000, 5'b00000, 5'b00010);
        run_alu("addi", 6'b000001, 3'b000, 5'b01100, 5'b00000);
        run_alu("sub",  6'b000010, 3'b001, 5'b00000, 5'b00010);
        run_alu("ori",  6'b010000, 3'b101, 5'b01000, 5'b00000);
        run_alu("and",  6'b010001, 3'b110, 5'b00000, 5'b00010);
        run_alu("or",   6'b010010, 3'b101, 5'b00000, 5'b00010);
        run_alu("sll",  6'b011000, 3'b100, 5'b10000, 5'b00010);
        run_alu("slt",  6'b100110, 3'b010, 5'b00000, 5'b00010);

        // beq taken, then not taken
        step("beq1.IF",  6'b110100, 1'b1, 1'b0, mk(ST_IF,     EN_IR,    2'b00, 3'b000, 5'b00000));
        step("beq1.ID",  6'b110100, 1'b1, 1'b0, mk(ST_ID,     EN_NONE,  2'b00, 3'b000, 5'b00000));
        step("beq1.EXE", 6'b110100, 1'b1, 1'b0, mk(ST_EXE_BR, 5'b10000, 2'b01, 3'b001, 5'b00000));
        step("beq0.IF",  6'b110100, 1'b1, 1'b0, mk(ST_IF,     EN_IR,    2'b00, 3'b000, 5'b00000));
        step("beq0.ID",  6'b110100, 1'b1, 1'b0, mk(ST_ID,     EN_NONE,  2'b00, 3'b000, 5'b00000));
        step("beq0.EXE", 6'b000000, 1'b0, 1'b0, mk(ST_EXE_BR, 5'b10000, 2'b00, 3'b001, 5'b00000));

        // lw, with the IR field switched to sw after ID
        step("lw.IF",  6'b110001, 1'b0, 1'b0, mk(ST_IF,     EN_IR,    2'b00, 3'b000, 5'b00000));
        step("lw.ID",  6'b110001, 1'b0, 1'b0, mk(ST_ID,     EN_NONE,  2'b00, 3'b000, 5'b00000));
        step("lw.EXE", 6'b110000, 1'b0, 1'b0, mk(ST_EXE_LS, EN_NONE,  2'b00, 3'b000, 5'b01100));
        step("lw.MEM", 6'b110000, 1'b1, 1'b0, mk(ST_MEM,    5'b00010, 2'b00, 3'b000, 5'b00000));
        step("lw.WB",  6'b110000, 1'b0, 1'b0, mk(ST_WB_LD,  5'b10100, 2'b00, 3'b000, 5'b00001));

        // sw
        step("sw.IF",  6'b110000, 1'b0, 1'b0, mk(ST_IF,     EN_IR,    2'b00, 3'b000, 5'b00000));
        step("sw.ID",  6'b110000, 1'b0, 1'b0, mk(ST_ID,     EN_NONE,  2'b00, 3'b000, 5'b00000));
        step("sw.EXE", 6'b110001, 1'b0, 1'b0, mk(ST_EXE_LS, EN_NONE,  2'b00, 3'b000, 5'b01100));
        step("sw.MEM", 6'b110001, 1'b0, 1'b0, mk(ST_MEM,    5'b10001, 2'b00, 3'b000, 5'b00000));

        // j and an unknown opcode (NOP)
        step("j.IF",   6'b111000, 1'b0, 1'b0, mk(ST_IF, EN_IR,    2'b00, 3'b000, 5'b00000));
        step("j.ID",   6'b111000, 1'b0, 1'b0, mk(ST_ID, 5'b10000, 2'b10, 3'b000, 5'b00000));
        step("nop.IF", 6'b101010, 1'b0, 1'b0, mk(ST_IF, EN_IR,    2'b00, 3'b000, 5'b00000));
        step("nop.ID", 6'b101010, 1'b1, 1'b0, mk(ST_ID, 5'b10000, 2'b00, 3'b000, 5'b00000));

        // sw aborted by reset in MEM: no write, no PC update, restart at IF
        step("swr.IF",  6'b110000, 1'b0, 1'b0, mk(ST_IF,     EN_IR,   2'b00, 3'b000, 5'b00000));
        step("swr.ID",  6'b110000, 1'b0, 1'b0, mk(ST_ID,     EN_NONE, 2'b00, 3'b000, 5'b00000));
        step("swr.EXE", 6'b110000, 1'b0, 1'b0, mk(ST_EXE_LS, EN_NONE, 2'b00, 3'b000, 5'b01100));
        step("swr.MEM", 6'b110000, 1'b0, 1'b1, mk(ST_MEM,    EN_NONE, 2'b00, 3'b000, 5'b00000));
        step("swr.IF2", 6'b111111, 1'b0, 1'b0, mk(ST_IF,     EN_IR,   2'b00, 3'b000, 5'b00000));

        // halt: sticky, everything quiet regardless of opcode/zero
        step("halt.ID", 6'b111111, 1'b0, 1'b0, mk(ST_ID, EN_NONE, 2'b00, 3'b000, 5'b00000));
        for (int i = 0; i < 20; i++) begin
            logic [5:0] hop;
            hop = (i % 2 == 0) ? 6'b111000 : 6'b101010;
            step($sformatf("halt.%0d", i), hop, i[0], 1'b0,
                 mk(ST_ID, EN_NONE, 2'b00, 3'b000, 5'b00000));
        end
        step("halt.rst", 6'b111000, 1'b0, 1'b1, mk(ST_ID, EN_NONE,  2'b00, 3'b000, 5'b00000));
        step("post.IF",  6'b111000, 1'b0, 1'b0, mk(ST_IF, EN_IR,    2'b00, 3'b000, 5'b00000));
        step("post.ID",  6'b111000, 1'b0, 1'b0, mk(ST_ID, 5'b10000, 2'b10, 3'b000, 5'b00000));
        step("post.IF2", 6'b000000, 1'b0, 1'b0, mk(ST_IF, EN_IR,    2'b00, 3'b000, 5'b00000));

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
        @(posedge CLK);
        n_chk++;
        if (sb.size() != 0 || n_pop != n_push) begin
            n_fail++;
            $display("FAIL drain: got %0d checked of %0d queued, expected all checked", n_pop, n_push);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle control FSM for the MC-CPU datapath.
- Sits directly upstream of the ALU: it sequences each instruction through IF/ID/EXE/MEM/WB and drives ALUSel, the operand selects and every write enable.
- Consumes the instruction opcode from the IR and the ALU zero flag.
- One instruction in flight. No pipelining.

Parameters:
- OP_W, 6, opcode width.
- ST_W, 3, state register width (exported for debug).

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  reset, synchronous, active-high.
- opcode  in  OP_W  IR[31:26]; valid from ID onward.
- zero  in  1  ALU zero flag (from a SUB).
- PCWre  out  1  PC write enable.
- IRWre  out  1  IR write enable.
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target.
- ALUSrcA  out  1  0 rs, 1 shamt.
- ALUSrcB  out  1  0 rt, 1 extended immediate.
- ExtSel  out  1  0 zero-extend, 1 sign-extend.
- ALUSel  out  3  000 add, 001 sub, 010 slt, 011 srl, 100 sll, 101 or, 110 and, 111 xor.
- WrRegDst  out  1  0 rt, 1 rd.
- RegWre  out  1  register file write enable.
- DBDataSrc  out  1  0 ALUOut, 1 memory data.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- state  out  ST_W  current state (debug).

Behaviour:
- State encoding:
  - IF=000, ID=001, EXE_AL=110, EXE_BR=101, EXE_LS=010, MEM=011, WB_AL=111, WB_LD=100.
  - HALT is a sticky flag held in ID encoding with all enables 0.
- Opcodes:
  - add 000000, addi 000001, sub 000010, ori 010000, and 010001, or 010010, sll 011000, slt 100110.
  - sw 110000, lw 110001, beq 110100, j 111000, halt 111111.
  - Any other opcode is a NOP.
- Opcode latching: opcode is latched into op_q on the ID clock edge. All post-ID decode uses op_q, so IR changes after ID have no effect.
- Transitions (one state per clock):
  - IF->ID.
  - ID->EXE_AL for ALU ops, EXE_BR for beq, EXE_LS for lw/sw.
  - ID->IF for j and NOP. ID->HALT for halt.
  - EXE_AL->WB_AL->IF.
  - EXE_BR->IF.
  - EXE_LS->MEM.
  - MEM->IF for sw, MEM->WB_LD for lw.
  - WB_LD->IF.
- Latency in clocks, IF to the next IF: ALU ops 4, beq 3, sw 4, lw 5, j/NOP 2.
- Outputs are registered-state Moore decode, plus zero in EXE_BR. Every enable not listed below is 0.
- Per-state outputs:
  - IF: IRWre=1.
  - ID, j: PCWre=1, PCSrc=10.
  - ID, NOP: PCWre=1, PCSrc=00.
  - EXE_AL: ALUSel per op (addi→000, ori→101, sll→100 with ALUSrcA=1). ALUSrcB=1 for addi/ori. ExtSel=1 only for addi.
  - EXE_BR: ALUSel=001. PCWre=1. PCSrc=01 if zero=1, else 00.
  - EXE_LS: ALUSel=000, ALUSrcB=1, ExtSel=1.
  - MEM: mWR=1 for sw; sw also asserts PCWre=1, PCSrc=00. mRD=1 for lw.
  - WB_AL: RegWre=1, DBDataSrc=0, PCWre=1, PCSrc=00. WrRegDst=1 for R-type (add/sub/and/or/slt/sll), 0 for addi/ori.
  - WB_LD: RegWre=1, DBDataSrc=1, WrRegDst=0, PCWre=1, PCSrc=00.
- PCWre is asserted exactly once per instruction, in its final state. PC therefore updates on the same edge that enters IF.
- Reset:
  - RST=1 at an edge forces state=IF and op_q=0, and clears HALT.
  - All write enables (PCWre, IRWre, RegWre, mWR, mRD) are 0 during any cycle where RST=1, including mid-instruction. The instruction is aborted with no architectural write.
  - First IF occurs the cycle after RST deasserts.
- HALT persists until RST. zero and opcode are ignored while halted.
- zero is ignored outside EXE_BR.

Decomposition:
- Shared package mc_cpu_pkg holds: opcode constants, state encodings, ALUSel codes (shared with the ALU), PCSrc codes.
- One combinational sub-module, mc_ctrl_decode, maps op_q to instruction class (alu/br/ls/jmp/halt/nop), ALUSel, ALUSrcA/B, ExtSel and WrRegDst.
- The FSM top holds state, op_q, HALT and per-state enable gating.

Test Plan:
- Reset then add (000000) → states 000,001,110,111,000. RegWre=1 and WrRegDst=1 only in WB_AL. ALUSel=000 in EXE_AL. One PCWre pulse.
- beq with zero=1 in EXE_BR → PCSrc=01, PCWre=1, next state IF, 3 cycles total. Repeat with zero=0 → PCSrc=00.
- lw (110001) → 5 cycles. mRD=1 in MEM. RegWre=1, DBDataSrc=1 in WB_LD. sw (110000) → mWR=1 in MEM, RegWre never 1, 4 cycles.
- j (111000) → PCSrc=10, PCWre=1 in ID, back to IF next cycle. Unknown opcode 101010 → PCSrc=00, 2 cycles.
- halt (111111) → after ID all enables stay 0 for 20 cycles regardless of opcode/zero toggling. RST=1 for one cycle → resumes at IF.
- RST asserted in MEM of sw → mWR=0 that cycle, state=IF next, no PCWre pulse. Opcode changed after ID → outputs follow latched op_q.
